vram_access_arbiter: RTL

//   Shares the single-port frame-buffer VRAM between two requesters: the display
//   row prefetcher and the host pixel writer. A display fetch is triggered once per

---
 rtl/vram_access_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vram_access_arbiter.sv
// Arbitrates the single-port frame-buffer VRAM between the display row prefetcher
// (fixed priority, fixed-length bursts) and the host pixel writer (gap filler).
module vram_access_arbiter #(
  parameter int ROW_W      = 7,
  parameter int ROWS       = 96,
  parameter int LINE_WORDS = 16,
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ROW_W-1:0]  disp_row,
  output logic              disp_busy,
  output logic              disp_rd_valid,
  output logic [IDX_W-1:0]  disp_rd_idx,
  output logic [DATA_W-1:0] disp_rd_data,
  output logic              disp_overrun,
  input  logic              host_wr_valid,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, DISP_BURST, DISP_DRAIN, HOST_WR} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  state_t            state, state_d;
  logic [IDX_W-1:0]  word_cnt, word_cnt_d;
  logic [ROW_W-1:0]  cur_row, cur_row_d;
  logic [ROW_W-1:0]  pend_row;
  logic              pending;
  logic              req_ok;
  logic              start_burst;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;

  function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] row,
                                                 input logic [IDX_W-1:0] idx);
    return ADDR_W'({row, idx});
  endfunction

  assign req_ok        = disp_req && (32'(disp_row) < ROWS);
  assign start_burst   = (state == IDLE) && (pending || req_ok);
  // Ready is held low during reset so every output reads 0 while reset is asserted.
  assign host_wr_ready = !reset && (state == IDLE) && !pending && !req_ok;
  assign disp_busy     = (state == DISP_BURST) || (state == DISP_DRAIN);
  assign disp_rd_data  = disp_rd_valid ? mem_rdata : '0;

  always_comb begin
    state_d     = state;
    word_cnt_d  = word_cnt;
    cur_row_d   = cur_row;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state)
      IDLE: begin
        if (start_burst) begin
          state_d    = DISP_BURST;
          cur_row_d  = pending ? pend_row : disp_row;
          word_cnt_d = '0;
          mem_en_d   = 1'b1;
          mem_addr_d = row_addr(cur_row_d, '0);
        end else if (host_wr_valid && host_wr_ready) begin
          state_d     = HOST_WR;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = host_wr_addr;
          mem_wdata_d = host_wr_data;
        end
      end
      DISP_BURST: begin
        if (word_cnt == LAST_IDX) begin
          state_d    = DISP_DRAIN;
          word_cnt_d = '0;
        end else begin
          word_cnt_d = word_cnt + IDX_W'(1);
          mem_en_d   = 1'b1;
          mem_addr_d = row_addr(cur_row, word_cnt_d);
        end
      end
      DISP_DRAIN: state_d = IDLE;
      HOST_WR:    state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      cur_row   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_d;
      word_cnt  <= word_cnt_d;
      cur_row   <= cur_row_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  // One request may wait behind the active burst; anything beyond that is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending      <= 1'b0;
      pend_row     <= '0;
      disp_overrun <= 1'b0;
    end else if (start_burst) begin
      pending <= 1'b0;
      if (pending && req_ok) disp_overrun <= 1'b1;
    end else if (req_ok) begin
      if (pending) begin
        disp_overrun <= 1'b1;
      end else begin
        pending  <= 1'b1;
        pend_row <= disp_row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_rd_valid <= 1'b0;
      disp_rd_idx   <= '0;
    end else begin
      disp_rd_valid <= mem_en && !mem_we;
      disp_rd_idx   <= (mem_en && !mem_we) ? word_cnt : '0;
    end
  end

endmodule
